cursor_paleta_seq: RTL and testbench

Sequencer directly upstream of the palette-cursor X stage (cambiar_x). It holds the palette cursor cell index, moves it on left/right button pulses with wrap-around, and on each redraw request drives the downstream X stage with loadx, in_x, plus, sum and C. The downstream stage converts these into the pixel column 4*x+C or 4*x+3-C. One redraw is a forward sweep (sum=1, C=0..3) followed by a reverse sweep (sum=0, C=0..3): 8 column strobes in total.

---
 rtl/cursor_paleta_pkg.sv | 32 +++
 rtl/cursor_step_timer.sv | 29 ++
 rtl/cursor_paleta_seq.sv | 167 ++++++++++++++++
 tb/tb_cursor_paleta_seq.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cursor_paleta_pkg.sv
// Shared types, widths and the cursor wrap helper for the palette-cursor sequencer.
// Moves use an explicit compare against the limit, so X_MAX need not be a power of two.
package cursor_paleta_pkg;

   localparam int X_W      = 6;
   localparam int C_W      = 3;
   localparam int C_STEPS  = 4;
   localparam int N_PASSES = 2;
   localparam int CNT_W    = $clog2(C_STEPS);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_STEP = 3'd2,
      ST_WAIT = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   // One cell right (right=1) or left (right=0), wrapping between 0 and x_max.
   function automatic logic [X_W-1:0] step_cursor(input logic [X_W-1:0] cur,
                                                  input logic            right,
                                                  input logic [X_W-1:0] x_max);
      logic [X_W-1:0] nxt;
      if (right) begin
         nxt = (cur == x_max) ? '0 : cur + X_W'(1);
      end else begin
         nxt = (cur == '0) ? x_max : cur - X_W'(1);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/cursor_step_timer.sv
// Loadable down-counter that times the idle gap after each column strobe.
// expired is high in the last of STEP_WAIT cycles following a load.
module cursor_step_timer #(
   parameter int STEP_WAIT = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic expired
);

   localparam int CW = (STEP_WAIT > 0) ? $clog2(STEP_WAIT + 1) : 1;
   localparam logic [CW-1:0] LOAD_V = CW'((STEP_WAIT > 0) ? STEP_WAIT - 1 : 0);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= LOAD_V;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CW'(1);
      end
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/cursor_paleta_seq.sv
// Palette cursor holder and redraw sequencer feeding the downstream X stage.
// A redraw is one load strobe then 8 column strobes: forward sweep C=0..3, reverse sweep C=0..3.
module cursor_paleta_seq
   import cursor_paleta_pkg::*;
#(
   parameter int X_MAX     = 15,
   parameter int X_INIT    = 0,
   parameter int STEP_WAIT = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           btn_left,
   input  logic           btn_right,
   output logic [X_W-1:0] cursor_x,
   output logic [X_W-1:0] in_x,
   output logic           loadx,
   output logic           plus,
   output logic           sum,
   output logic [C_W-1:0] C,
   output logic           busy,
   output logic           done,
   output logic [2:0]     dbg_state_o
);

   localparam logic [X_W-1:0]   XMAX_V   = X_W'(X_MAX);
   localparam logic [X_W-1:0]   XINIT_V  = X_W'(X_INIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_STEPS - 1);

   state_t           state_q;
   logic [X_W-1:0]   cursor_q;
   logic [X_W-1:0]   in_x_q;
   logic             loadx_q;
   logic             plus_q;
   logic             sum_q;
   logic [C_W-1:0]   c_q;
   logic             busy_q;
   logic             done_q;
   logic [CNT_W-1:0] cnt_q;
   logic             pass_q;
   logic             pend_valid_q;
   logic             pend_right_q;

   logic             move_req;
   logic [X_W-1:0]   cursor_moved_d;
   logic             eff_valid;
   logic             eff_right;
   logic [X_W-1:0]   cursor_pend_d;
   logic [CNT_W-1:0] cnt_d;
   logic             pass_d;
   logic             last_step;
   logic             advance;
   logic             timer_load;
   logic             timer_expired;

   // Both buttons together cancel out and leave no trace.
   assign move_req       = btn_left ^ btn_right;
   assign cursor_moved_d = move_req ? step_cursor(cursor_q, btn_right, XMAX_V) : cursor_q;

   // A press during the DONE cycle is the newest move and overrides the stored one.
   assign eff_valid     = move_req | pend_valid_q;
   assign eff_right     = move_req ? btn_right : pend_right_q;
   assign cursor_pend_d = eff_valid ? step_cursor(cursor_q, eff_right, XMAX_V) : cursor_q;

   assign cnt_d     = cnt_q + CNT_W'(1);
   assign pass_d    = pass_q ^ (cnt_q == CNT_LAST);
   assign last_step = pass_q & (cnt_q == CNT_LAST);

   assign timer_load = (state_q == ST_STEP);
   assign advance    = ((state_q == ST_STEP) && (STEP_WAIT == 0)) ||
                       ((state_q == ST_WAIT) && timer_expired);

   cursor_step_timer #(
      .STEP_WAIT(STEP_WAIT)
   ) u_step_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (timer_load),
      .expired(timer_expired)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         cursor_q     <= XINIT_V;
         in_x_q       <= XINIT_V;
         loadx_q      <= 1'b0;
         plus_q       <= 1'b0;
         sum_q        <= 1'b1;
         c_q          <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         cnt_q        <= '0;
         pass_q       <= 1'b0;
         pend_valid_q <= 1'b0;
         pend_right_q <= 1'b0;
      end else begin
         if ((state_q != ST_IDLE) && move_req) begin
            pend_valid_q <= 1'b1;
            pend_right_q <= btn_right;
         end

         case (state_q)
            ST_IDLE: begin
               cursor_q <= cursor_moved_d;
               if (start) begin
                  state_q <= ST_LOAD;
                  loadx_q <= 1'b1;
                  in_x_q  <= cursor_moved_d;
                  busy_q  <= 1'b1;
               end
            end

            ST_LOAD: begin
               state_q <= ST_STEP;
               loadx_q <= 1'b0;
               cnt_q   <= '0;
               pass_q  <= 1'b0;
               plus_q  <= 1'b1;
               sum_q   <= 1'b1;
               c_q     <= '0;
            end

            ST_STEP, ST_WAIT: begin
               if (advance) begin
                  if (last_step) begin
                     state_q <= ST_DONE;
                     plus_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_STEP;
                     plus_q  <= 1'b1;
                     cnt_q   <= cnt_d;
                     pass_q  <= pass_d;
                     c_q     <= C_W'(cnt_d);
                     sum_q   <= ~pass_d;
                  end
               end else if (state_q == ST_STEP) begin
                  state_q <= ST_WAIT;
                  plus_q  <= 1'b0;
               end
            end

            ST_DONE: begin
               state_q      <= ST_IDLE;
               done_q       <= 1'b0;
               busy_q       <= 1'b0;
               cursor_q     <= cursor_pend_d;
               pend_valid_q <= 1'b0;
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign cursor_x    = cursor_q;
   assign in_x        = in_x_q;
   assign loadx       = loadx_q;
   assign plus        = plus_q;
   assign sum         = sum_q;
   assign C           = c_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cursor_paleta_seq.sv
// Directed bench: one DUT with STEP_WAIT=2/X_INIT=5, a second with STEP_WAIT=0/X_INIT=0.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_cursor_paleta_seq;

   logic       clk;
   logic       rst;
   logic       start, btn_left, btn_right;
   logic [5:0] cursor_x, in_x;
   logic       loadx, plus, sum, busy, done;
   logic [2:0] c_out, dbg_state;

   logic       start0, bl0, br0;
   logic [5:0] cursor_x0, in_x0;
   logic       loadx0, plus0, sum0, busy0, done0;
   logic [2:0] c_out0, dbg_state0;

   int vectors;
   int errors;

   cursor_paleta_seq #(.X_MAX(15), .X_INIT(5), .STEP_WAIT(2)) dut (
      .clk(clk), .rst(rst), .start(start), .btn_left(btn_left), .btn_right(btn_right),
      .cursor_x(cursor_x), .in_x(in_x), .loadx(loadx), .plus(plus), .sum(sum),
      .C(c_out), .busy(busy), .done(done), .dbg_state_o(dbg_state)
   );

   cursor_paleta_seq #(.X_MAX(15), .X_INIT(0), .STEP_WAIT(0)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .btn_left(bl0), .btn_right(br0),
      .cursor_x(cursor_x0), .in_x(in_x0), .loadx(loadx0), .plus(plus0), .sum(sum0),
      .C(c_out0), .busy(busy0), .done(done0), .dbg_state_o(dbg_state0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      start = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
      start0 = 1'b0; bl0 = 1'b0; br0 = 1'b0;
      tick();
      tick();
      vectors++;
      if ({cursor_x, in_x} !== {6'd5, 6'd5}) begin
         errors++;
         $display("FAIL reset_cursor got=%0d/%0d exp=5/5", cursor_x, in_x);
      end
      vectors++;
      if ({loadx, plus, done, busy, sum, c_out} !== {4'b0000, 1'b1, 3'd0}) begin
         errors++;
         $display("FAIL reset_ctrl got=%b exp=%b", {loadx, plus, done, busy, sum, c_out}, 8'b00001000);
      end
      vectors++;
      if ({cursor_x0, plus0, busy0, sum0} !== {6'd0, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_dut0 got=%b exp=%b", {cursor_x0, plus0, busy0, sum0}, 9'b000000001);
      end
      @(negedge clk);
      rst = 1'b1;
      tick();
   endtask

   task automatic test_redraw();
      logic       exp_plus;
      logic       exp_sum;
      logic [2:0] exp_c;
      int         n;
      start = 1'b1;
      for (int j = 1; j <= 28; j++) begin
         tick();
         start = 1'b0;
         exp_plus = (j >= 2) && (j <= 23) && (((j - 2) % 3) == 0);
         vectors++;
         if (loadx !== (j == 1)) begin
            errors++;
            $display("FAIL redraw_loadx j=%0d got=%b exp=%b", j, loadx, (j == 1));
         end
         vectors++;
         if (plus !== exp_plus) begin
            errors++;
            $display("FAIL redraw_plus j=%0d got=%b exp=%b", j, plus, exp_plus);
         end
         if (exp_plus) begin
            n = (j - 2) / 3;
            exp_sum = (n < 4);
            exp_c = 3'(n % 4);
            vectors++;
            if ({sum, c_out} !== {exp_sum, exp_c}) begin
               errors++;
               $display("FAIL redraw_sumc j=%0d got=%b/%0d exp=%b/%0d", j, sum, c_out, exp_sum, exp_c);
            end
         end
         vectors++;
         if (done !== (j == 26)) begin
            errors++;
            $display("FAIL redraw_done j=%0d got=%b exp=%b", j, done, (j == 26));
         end
         vectors++;
         if (busy !== ((j >= 1) && (j <= 26))) begin
            errors++;
            $display("FAIL redraw_busy j=%0d got=%b exp=%b", j, busy, ((j >= 1) && (j <= 26)));
         end
         vectors++;
         if (in_x !== 6'd5) begin
            errors++;
            $display("FAIL redraw_in_x j=%0d got=%0d exp=5", j, in_x);
         end
      end
   endtask

   task automatic test_moves();
      logic [5:0] exp_x [0:13];
      logic [1:0] btn   [0:13];
      exp_x = '{6'd4, 6'd3, 6'd2, 6'd1, 6'd0, 6'd15, 6'd0, 6'd15, 6'd15,
                6'd0, 6'd1, 6'd2, 6'd3, 6'd3};
      btn   = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b11,
                2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
      for (int i = 0; i < 14; i++) begin
         {btn_left, btn_right} = btn[i];
         tick();
         btn_left = 1'b0;
         btn_right = 1'b0;
         vectors++;
         if (cursor_x !== exp_x[i]) begin
            errors++;
            $display("FAIL move step=%0d got=%0d exp=%0d", i, cursor_x, exp_x[i]);
         end
      end
   endtask

   task automatic test_move_while_busy();
      start = 1'b1;
      for (int j = 1; j <= 27; j++) begin
         tick();
         start = 1'b0;
         btn_left = 1'b0;
         btn_right = 1'b0;
         if (j == 3 || j == 12) btn_right = 1'b1;
         if (j == 8) btn_left = 1'b1;
         if (j <= 26) begin
            vectors++;
            if ({in_x, cursor_x} !== {6'd3, 6'd3}) begin
               errors++;
               $display("FAIL busy_move_hold j=%0d got=%0d/%0d exp=3/3", j, in_x, cursor_x);
            end
         end else begin
            vectors++;
            if (cursor_x !== 6'd4) begin
               errors++;
               $display("FAIL busy_move_apply got=%0d exp=4", cursor_x);
            end
         end
      end
   endtask

   task automatic test_start_while_busy();
      int plus_cnt;
      int done_cnt;
      int load_cnt;
      plus_cnt = 0; done_cnt = 0; load_cnt = 0;
      start = 1'b1;
      for (int j = 1; j <= 40; j++) begin
         tick();
         start = (j == 8);
         if (plus) plus_cnt++;
         if (done) done_cnt++;
         if (loadx) load_cnt++;
         if (j == 1) begin
            vectors++;
            if (in_x !== 6'd4) begin
               errors++;
               $display("FAIL restart_in_x got=%0d exp=4", in_x);
            end
         end
      end
      start = 1'b0;
      vectors++;
      if (plus_cnt != 8) begin
         errors++;
         $display("FAIL restart_plus_count got=%0d exp=8", plus_cnt);
      end
      vectors++;
      if (done_cnt != 1) begin
         errors++;
         $display("FAIL restart_done_count got=%0d exp=1", done_cnt);
      end
      vectors++;
      if (load_cnt != 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL restart_no_second got=%0d/%b exp=1/0", load_cnt, busy);
      end
   endtask

   task automatic test_async_reset();
      int stray;
      stray = 0;
      start = 1'b1;
      for (int j = 1; j <= 12; j++) begin
         tick();
         start = 1'b0;
      end
      vectors++;
      if ({plus, busy, c_out} !== {1'b0, 1'b1, 3'd3}) begin
         errors++;
         $display("FAIL arst_pre got=%b exp=%b", {plus, busy, c_out}, 5'b01011);
      end
      #3;
      rst = 1'b0;
      #1;
      vectors++;
      if ({cursor_x, in_x} !== {6'd5, 6'd5}) begin
         errors++;
         $display("FAIL arst_cursor got=%0d/%0d exp=5/5", cursor_x, in_x);
      end
      vectors++;
      if ({loadx, plus, done, busy, sum, c_out} !== {4'b0000, 1'b1, 3'd0}) begin
         errors++;
         $display("FAIL arst_ctrl got=%b exp=%b", {loadx, plus, done, busy, sum, c_out}, 8'b00001000);
      end
      @(posedge clk);
      #3;
      rst = 1'b1;
      for (int j = 0; j < 30; j++) begin
         tick();
         if (plus || done || busy || loadx) stray++;
      end
      vectors++;
      if (stray != 0) begin
         errors++;
         $display("FAIL arst_quiet got=%0d exp=0", stray);
      end
   endtask

   task automatic test_no_wait();
      logic [2:0] exp_c;
      start0 = 1'b1;
      for (int j = 1; j <= 12; j++) begin
         tick();
         start0 = 1'b0;
         vectors++;
         if (loadx0 !== (j == 1) || plus0 !== ((j >= 2) && (j <= 9))) begin
            errors++;
            $display("FAIL nowait_strobe j=%0d got=%b%b exp=%b%b", j, loadx0, plus0,
                     (j == 1), ((j >= 2) && (j <= 9)));
         end
         if ((j >= 2) && (j <= 9)) begin
            exp_c = 3'((j - 2) % 4);
            vectors++;
            if ({sum0, c_out0} !== {(j <= 5), exp_c}) begin
               errors++;
               $display("FAIL nowait_sumc j=%0d got=%b/%0d exp=%b/%0d", j, sum0, c_out0, (j <= 5), exp_c);
            end
         end
         vectors++;
         if (done0 !== (j == 10)) begin
            errors++;
            $display("FAIL nowait_done j=%0d got=%b exp=%b", j, done0, (j == 10));
         end
      end
   endtask

   initial begin
      vectors = 0;
      errors = 0;
      test_reset();
      test_redraw();
      test_moves();
      test_move_while_busy();
      test_start_while_busy();
      test_async_reset();
      test_no_wait();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
